// File: rtl/chess_pkg.sv
// Shared chess definitions for the board-controller blocks.
//
// Contents:
//   - piece code constants (0 = empty, 1..6 white, 7..12 black, 13..15 illegal)
//   - player encoding (0 = white, 1 = black)
//   - pawn start ranks for the double step
//   - piece_type_t and decode_piece(): split a 4-bit board code into colour
//     and colour-independent piece type
package chess_pkg;

    localparam logic [3:0] PC_EMPTY  = 4'd0;
    localparam logic [3:0] PC_W_KING = 4'd6;
    localparam logic [3:0] PC_B_KING = 4'd12;
    // A black piece code is the white code plus this offset.
    localparam logic [3:0] PC_BLACK_OFFSET = 4'd6;

    localparam logic PLAYER_WHITE = 1'b0;
    localparam logic PLAYER_BLACK = 1'b1;

    localparam logic [2:0] WHITE_PAWN_RANK = 3'd1;
    localparam logic [2:0] BLACK_PAWN_RANK = 3'd6;

    typedef enum logic [2:0] {
        PT_NONE    = 3'd0,
        PT_PAWN    = 3'd1,
        PT_ROOK    = 3'd2,
        PT_KNIGHT  = 3'd3,
        PT_BISHOP  = 3'd4,
        PT_QUEEN   = 3'd5,
        PT_KING    = 3'd6,
        PT_ILLEGAL = 3'd7
    } piece_type_t;

    typedef struct packed {
        logic        colour;
        piece_type_t ptype;
    } piece_info_t;

    // Codes 13..15 decode as PT_ILLEGAL; they carry the black colour only
    // because their top bit is set, which is irrelevant for an illegal mover.
    function automatic piece_info_t decode_piece(input logic [3:0] code);
        piece_info_t info;
        logic [3:0]  black_code;
        black_code  = code - PC_BLACK_OFFSET;
        info.colour = PLAYER_WHITE;
        info.ptype  = PT_NONE;
        if (code == PC_EMPTY) begin
            info.ptype = PT_NONE;
        end else if (code <= PC_W_KING) begin
            info.ptype = piece_type_t'(code[2:0]);
        end else if (code <= PC_B_KING) begin
            info.colour = PLAYER_BLACK;
            info.ptype  = piece_type_t'(black_code[2:0]);
        end else begin
            info.colour = PLAYER_BLACK;
            info.ptype  = PT_ILLEGAL;
        end
        return info;
    endfunction

endpackage

// File: rtl/piece_geometry.sv
// Combinational movement-shape check for one piece.
//
// Ports:
//   ptype            in  3  piece type (piece_type_t encoding)
//   colour           in  1  mover colour, selects pawn direction
//   src_x            in  3  source rank, for the pawn double step
//   dx, dy           in  4  signed destination minus source
//   geom_ok          out 1  shape is legal for this piece (and not a null move)
//   needs_empty_dest out 1  pawn straight move: destination must be empty
//   needs_capture    out 1  pawn diagonal: destination must hold an opponent
//   step_x, step_y   out 3  per-square path step, two's complement (-1/0/+1)
//   path_len         out 3  number of intermediate squares to scan
module piece_geometry
    import chess_pkg::*;
(
    input  logic [2:0] ptype,
    input  logic       colour,
    input  logic [2:0] src_x,
    input  logic [3:0] dx,
    input  logic [3:0] dy,
    output logic       geom_ok,
    output logic       needs_empty_dest,
    output logic       needs_capture,
    output logic [2:0] step_x,
    output logic [2:0] step_y,
    output logic [2:0] path_len
);

    logic [2:0] adx, ady, amax;
    logic       moved;
    logic       shape_ok;
    logic [3:0] pawn_one, pawn_two;
    logic [2:0] pawn_rank;

    // |d| never exceeds 7, so negating the low three bits is exact.
    assign adx  = dx[3] ? (3'd0 - dx[2:0]) : dx[2:0];
    assign ady  = dy[3] ? (3'd0 - dy[2:0]) : dy[2:0];
    assign amax = (adx > ady) ? adx : ady;

    assign moved = (dx != 4'd0) || (dy != 4'd0);

    assign step_x = (dx == 4'd0) ? 3'd0 : (dx[3] ? 3'b111 : 3'b001);
    assign step_y = (dy == 4'd0) ? 3'd0 : (dy[3] ? 3'b111 : 3'b001);

    // White pawns advance towards higher ranks, black towards lower.
    assign pawn_one  = (colour == PLAYER_BLACK) ? 4'b1111 : 4'b0001;
    assign pawn_two  = (colour == PLAYER_BLACK) ? 4'b1110 : 4'b0010;
    assign pawn_rank = (colour == PLAYER_BLACK) ? BLACK_PAWN_RANK : WHITE_PAWN_RANK;

    always_comb begin
        shape_ok         = 1'b0;
        needs_empty_dest = 1'b0;
        needs_capture    = 1'b0;
        path_len         = 3'd0;
        case (ptype)
            PT_ROOK: begin
                shape_ok = (adx == 3'd0) || (ady == 3'd0);
                path_len = amax - 3'd1;
            end
            PT_BISHOP: begin
                shape_ok = (adx == ady);
                path_len = amax - 3'd1;
            end
            PT_QUEEN: begin
                shape_ok = (adx == 3'd0) || (ady == 3'd0) || (adx == ady);
                path_len = amax - 3'd1;
            end
            PT_KING: begin
                shape_ok = (adx <= 3'd1) && (ady <= 3'd1);
            end
            PT_KNIGHT: begin
                shape_ok = ((adx == 3'd1) && (ady == 3'd2)) ||
                           ((adx == 3'd2) && (ady == 3'd1));
            end
            PT_PAWN: begin
                if ((dx == pawn_one) && (ady <= 3'd1)) begin
                    shape_ok         = 1'b1;
                    needs_empty_dest = (ady == 3'd0);
                    needs_capture    = (ady != 3'd0);
                end else if ((dx == pawn_two) && (ady == 3'd0) && (src_x == pawn_rank)) begin
                    shape_ok         = 1'b1;
                    needs_empty_dest = 1'b1;
                    path_len         = 3'd1;
                end
            end
            default: begin
                shape_ok = 1'b0;
            end
        endcase
        // A null move is never legal; path_len is don't-care when this is 0.
        geom_ok = shape_ok && moved;
    end

endmodule

// File: rtl/move_validator.sv
// Destination-validation responder for the board controller.
//
// On a start request the move is latched, its shape checked, then the
// destination and any intermediate squares are read one at a time through
// the shared square-read port (one-cycle read latency) and judged.
//
// Ports:
//   clk                       system clock
//   reset                     synchronous, active-low
//   start                     level request; dropping it aborts to idle
//   current_player            0 = white, 1 = black
//   piece_to_move             mover's piece code
//   piece_x, piece_y          source square (x = rank, y = file)
//   move_x, move_y            destination square
//   validate_square           board read data, one cycle after the address
//   validate_x, validate_y    registered board read address
//   done                      result available, held until start falls
//   valid                     move legal (meaningful while done = 1)
//
// Build option: define MOVE_VALIDATOR_OWNERSHIP_EN to also reject a mover
// whose colour differs from current_player.
module move_validator
    import chess_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       current_player,
    input  logic [3:0] piece_to_move,
    input  logic [2:0] piece_x,
    input  logic [2:0] piece_y,
    input  logic [2:0] move_x,
    input  logic [2:0] move_y,
    input  logic [3:0] validate_square,
    output logic [2:0] validate_x,
    output logic [2:0] validate_y,
    output logic       done,
    output logic       valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEOM,
        S_READ_DEST,
        S_CHECK_DEST,
        S_PATH_READ,
        S_PATH_CHECK,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] piece_reg, piece_next;
    logic [2:0] px_reg, px_next, py_reg, py_next;
    logic [2:0] mx_reg, mx_next, my_reg, my_next;
    logic [2:0] addr_x_reg, addr_x_next, addr_y_reg, addr_y_next;
    logic [2:0] remain_reg, remain_next;
    logic       result_reg, result_next;
    logic       done_reg, done_next;
    logic       valid_reg, valid_next;

    piece_info_t mover_info, square_info;
    logic [3:0]  dx, dy;
    logic        geom_ok, needs_empty_dest, needs_capture;
    logic [2:0]  step_x, step_y, path_len;
    logic        owner_reject, off_board, geom_reject;
    logic        occupied, dest_reject;

    assign mover_info  = decode_piece(piece_reg);
    assign square_info = decode_piece(validate_square);

    assign dx = {1'b0, mx_reg} - {1'b0, px_reg};
    assign dy = {1'b0, my_reg} - {1'b0, py_reg};

    piece_geometry u_geom (
        .ptype            (mover_info.ptype),
        .colour           (mover_info.colour),
        .src_x            (px_reg),
        .dx               (dx),
        .dy               (dy),
        .geom_ok          (geom_ok),
        .needs_empty_dest (needs_empty_dest),
        .needs_capture    (needs_capture),
        .step_x           (step_x),
        .step_y           (step_y),
        .path_len         (path_len)
    );

`ifdef MOVE_VALIDATOR_OWNERSHIP_EN
    logic player_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            player_reg <= PLAYER_WHITE;
        end else if (state_reg == S_IDLE && start) begin
            player_reg <= current_player;
        end
    end

    assign owner_reject = (mover_info.colour != player_reg);
`else
    // Colour is judged from the mover itself, so the player input is ignored.
    logic unused_player;
    assign unused_player = current_player;
    assign owner_reject  = 1'b0;
`endif

    // Only bites when the block is built for a board smaller than 8x8.
    assign off_board = (int'(mx_reg) >= ROWS) || (int'(my_reg) >= ROWS);

    assign geom_reject = (mover_info.ptype == PT_NONE) || (mover_info.ptype == PT_ILLEGAL) ||
                         !geom_ok || owner_reject || off_board;

    assign occupied    = (square_info.ptype != PT_NONE);
    assign dest_reject = (occupied && (square_info.colour == mover_info.colour)) ||
                         (occupied && needs_empty_dest) ||
                         (!occupied && needs_capture);

    always_comb begin
        state_next  = state_reg;
        piece_next  = piece_reg;
        px_next     = px_reg;
        py_next     = py_reg;
        mx_next     = mx_reg;
        my_next     = my_reg;
        addr_x_next = addr_x_reg;
        addr_y_next = addr_y_reg;
        remain_next = remain_reg;
        result_next = result_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    piece_next = piece_to_move;
                    px_next    = piece_x;
                    py_next    = piece_y;
                    mx_next    = move_x;
                    my_next    = move_y;
                    state_next = S_GEOM;
                end
            end
            S_GEOM: begin
                if (geom_reject) begin
                    result_next = 1'b0;
                    state_next  = S_DONE;
                end else begin
                    addr_x_next = mx_reg;
                    addr_y_next = my_reg;
                    state_next  = S_READ_DEST;
                end
            end
            S_READ_DEST: begin
                state_next = S_CHECK_DEST;
            end
            S_CHECK_DEST: begin
                if (dest_reject) begin
                    result_next = 1'b0;
                    state_next  = S_DONE;
                end else if (path_len == 3'd0) begin
                    result_next = 1'b1;
                    state_next  = S_DONE;
                end else begin
                    addr_x_next = px_reg + step_x;
                    addr_y_next = py_reg + step_y;
                    remain_next = path_len;
                    state_next  = S_PATH_READ;
                end
            end
            S_PATH_READ: begin
                state_next = S_PATH_CHECK;
            end
            S_PATH_CHECK: begin
                if (occupied) begin
                    result_next = 1'b0;
                    state_next  = S_DONE;
                end else if (remain_reg == 3'd1) begin
                    result_next = 1'b1;
                    state_next  = S_DONE;
                end else begin
                    addr_x_next = addr_x_reg + step_x;
                    addr_y_next = addr_y_reg + step_y;
                    remain_next = remain_reg - 3'd1;
                    state_next  = S_PATH_READ;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Losing the memory grant abandons whatever is in flight.
        if (state_reg != S_IDLE && !start) begin
            state_next = S_IDLE;
        end

        // Outputs trail entry into S_DONE by one edge and drop with start.
        done_next  = (state_reg == S_DONE) && start;
        valid_next = done_next && result_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            piece_reg  <= PC_EMPTY;
            px_reg     <= 3'd0;
            py_reg     <= 3'd0;
            mx_reg     <= 3'd0;
            my_reg     <= 3'd0;
            addr_x_reg <= 3'd0;
            addr_y_reg <= 3'd0;
            remain_reg <= 3'd0;
            result_reg <= 1'b0;
            done_reg   <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            piece_reg  <= piece_next;
            px_reg     <= px_next;
            py_reg     <= py_next;
            mx_reg     <= mx_next;
            my_reg     <= my_next;
            addr_x_reg <= addr_x_next;
            addr_y_reg <= addr_y_next;
            remain_reg <= remain_next;
            result_reg <= result_next;
            done_reg   <= done_next;
            valid_reg  <= valid_next;
        end
    end

    assign validate_x = addr_x_reg;
    assign validate_y = addr_y_reg;
    assign done       = done_reg;
    assign valid      = valid_reg;

endmodule

// File: tb/tb_move_validator.sv
module tb_move_validator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       current_player;
    logic [3:0] piece_to_move;
    logic [2:0] piece_x, piece_y, move_x, move_y;
    logic [3:0] validate_square;
    logic [2:0] validate_x, validate_y;
    logic       done, valid;

    int checks   = 0;
    int failures = 0;

    logic [3:0] board [8][8];
    int back_row [8] = '{2, 3, 4, 5, 6, 4, 3, 2};

    // Model results for the current move.
    int exp_lat;
    bit exp_valid;
    int exp_addr[$];
    // Observed results for the current move.
    int meas_lat;
    int meas_valid;
    int got_addr[$];

    always #5 clk = ~clk;

    // Board memory: registered read, data one cycle after the address.
    always @(posedge clk) validate_square <= board[validate_x][validate_y];

    move_validator dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .current_player  (current_player),
        .piece_to_move   (piece_to_move),
        .piece_x         (piece_x),
        .piece_y         (piece_y),
        .move_x          (move_x),
        .move_y          (move_y),
        .validate_square (validate_square),
        .validate_x      (validate_x),
        .validate_y      (validate_y),
        .done            (done),
        .valid           (valid)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clear_board();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                board[x][y] = 4'd0;
    endtask

    task automatic set_standard();
        clear_board();
        for (int y = 0; y < 8; y++) begin
            board[0][y] = 4'(back_row[y]);
            board[1][y] = 4'd1;
            board[6][y] = 4'd7;
            board[7][y] = 4'(back_row[y] + 6);
        end
    endtask

    // Chess-rule model: result, edge at which done rises, and the squares read.
    task automatic model(input int pc, input int px, input int py,
                         input int mx, input int my, input int pl);
        int dx, dy, adx, ady, t, fwd, srank, k, sx, sy, d, big;
        bit black, g, straight, capture;
        dx = mx - px;
        dy = my - py;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        big = (adx > ady) ? adx : ady;
        exp_addr.delete();
        exp_valid = 1'b0;
        exp_lat   = 2;
        g = 0; straight = 0; capture = 0; k = 0;
        black = (pc >= 7);
        t = black ? pc - 6 : pc;
        if (pc >= 1 && pc <= 12 && (adx + ady) != 0) begin
            case (t)
                1: begin
                    fwd   = black ? -1 : 1;
                    srank = black ? 6 : 1;
                    if (dx == fwd && ady <= 1) begin
                        g = 1; straight = (ady == 0); capture = (ady == 1);
                    end else if (dx == 2 * fwd && dy == 0 && px == srank) begin
                        g = 1; straight = 1; k = 1;
                    end
                end
                2: begin g = (dx == 0 || dy == 0); k = big - 1; end
                3: g = (adx * ady == 2);
                4: begin g = (adx == ady); k = big - 1; end
                5: begin g = (dx == 0 || dy == 0 || adx == ady); k = big - 1; end
                6: g = (adx <= 1 && ady <= 1);
                default: g = 0;
            endcase
        end
`ifdef MOVE_VALIDATOR_OWNERSHIP_EN
        if (black != (pl != 0)) g = 0;
`endif
        if (!g) return;
        exp_addr.push_back(mx * 8 + my);
        exp_lat = 4;
        d = int'(board[mx][my]);
        if (d != 0 && ((d >= 7) == black)) return;
        if (straight && d != 0) return;
        if (capture && d == 0) return;
        sx = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
        sy = (dy > 0) ? 1 : ((dy < 0) ? -1 : 0);
        for (int j = 1; j <= k; j++) begin
            exp_addr.push_back((px + j * sx) * 8 + (py + j * sy));
            exp_lat = 4 + 2 * j;
            if (board[px + j * sx][py + j * sy] != 4'd0) return;
        end
        exp_lat   = 4 + 2 * k;
        exp_valid = 1'b1;
    endtask

    // Runs one request and compares every cycle against the model.
    task automatic run_move(input string nm, input int pc, input int px, input int py,
                            input int mx, input int my, input int pl);
        model(pc, px, py, mx, my, pl);
        got_addr.delete();
        meas_lat   = -1;
        meas_valid = 0;
        @(negedge clk);
        piece_to_move  = 4'(pc);
        piece_x        = 3'(px);
        piece_y        = 3'(py);
        move_x         = 3'(mx);
        move_y         = 3'(my);
        current_player = 1'(pl);
        start          = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                // Inputs must have been latched; garbage from here on.
                piece_to_move  = 4'($urandom_range(0, 15));
                piece_x        = 3'($urandom_range(0, 7));
                piece_y        = 3'($urandom_range(0, 7));
                move_x         = 3'($urandom_range(0, 7));
                move_y         = 3'($urandom_range(0, 7));
                current_player = 1'($urandom_range(0, 1));
            end
            if ((n % 2) == 1 && got_addr.size() < exp_addr.size()) begin
                got_addr.push_back(int'(validate_x) * 8 + int'(validate_y));
                check({nm, "_addr"}, got_addr[got_addr.size() - 1], exp_addr[got_addr.size() - 1]);
            end
            check({nm, "_done"}, int'(done), (n >= exp_lat) ? 1 : 0);
            if (done === 1'b1 && meas_lat < 0) begin
                meas_lat   = n;
                meas_valid = int'(valid);
            end
            if (n >= exp_lat) begin
                check({nm, "_valid"}, int'(valid), int'(exp_valid));
                break;
            end
        end
        @(posedge clk); #1;
        check({nm, "_hold_done"}, int'(done), 1);
        check({nm, "_hold_valid"}, int'(valid), int'(exp_valid));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({nm, "_release_done"}, int'(done), 0);
        check({nm, "_release_valid"}, int'(valid), 0);
        $display("move %s piece=%0d (%0d,%0d)->(%0d,%0d) player=%0d done_edge=%0d valid=%0d expected_edge=%0d expected_valid=%0d",
                 nm, pc, px, py, mx, my, pl, meas_lat, meas_valid, exp_lat, exp_valid);
    endtask

    initial begin
        int quiet;
        int waited;
        reset          = 1'b0;
        start          = 1'b0;
        current_player = 1'b0;
        piece_to_move  = 4'd0;
        piece_x        = 3'd0;
        piece_y        = 3'd0;
        move_x         = 3'd0;
        move_y         = 3'd0;
        clear_board();

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", int'(done), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_vx", int'(validate_x), 0);
        check("reset_vy", int'(validate_y), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Standard opening position.
        set_standard();
        run_move("pawn_double", 1, 1, 4, 3, 4, 0);
        check("pin_pawn_double_edge", meas_lat, 6);
        check("pin_pawn_double_valid", meas_valid, 1);

        run_move("rook_blocked", 2, 0, 0, 3, 0, 0);
        check("pin_rook_edge", meas_lat, 6);
        check("pin_rook_valid", meas_valid, 0);
        check("pin_rook_addr0", (got_addr.size() > 0) ? got_addr[0] : -1, 3 * 8 + 0);
        check("pin_rook_addr1", (got_addr.size() > 1) ? got_addr[1] : -1, 1 * 8 + 0);

        run_move("knight", 3, 0, 1, 2, 2, 0);
        check("pin_knight_edge", meas_lat, 4);
        check("pin_knight_valid", meas_valid, 1);

        run_move("foreign_pawn", 7, 6, 0, 5, 0, 0);
`ifdef MOVE_VALIDATOR_OWNERSHIP_EN
        check("pin_foreign_edge", meas_lat, 2);
        check("pin_foreign_valid", meas_valid, 0);
`else
        check("pin_foreign_edge", meas_lat, 4);
        check("pin_foreign_valid", meas_valid, 1);
`endif

        run_move("queen_own", 5, 0, 3, 1, 3, 0);
        check("pin_queen_own_edge", meas_lat, 4);
        check("pin_queen_own_valid", meas_valid, 0);

        run_move("pawn_diag_empty", 1, 1, 4, 2, 5, 0);
        check("pin_pawn_diag_edge", meas_lat, 4);
        check("pin_pawn_diag_valid", meas_valid, 0);

        run_move("black_knight", 9, 7, 1, 5, 2, 1);
        run_move("bishop_blocked", 4, 0, 2, 2, 4, 0);
        run_move("king_null", 6, 0, 4, 0, 4, 0);
        check("pin_null_edge", meas_lat, 2);
        run_move("illegal_code", 13, 0, 4, 1, 4, 0);
        run_move("empty_code", 0, 3, 3, 4, 3, 0);
        run_move("pawn_bad_double", 1, 2, 2, 4, 2, 0);

        // Sparse board for long paths and captures.
        clear_board();
        board[0][0] = 4'd2;
        board[7][0] = 4'd8;
        board[3][3] = 4'd1;
        board[4][4] = 4'd7;
        board[6][2] = 4'd7;
        board[5][2] = 4'd3;
        run_move("rook_long_capture", 2, 0, 0, 7, 0, 0);
        check("pin_max_latency", meas_lat, 16);
        check("pin_max_valid", meas_valid, 1);
        run_move("pawn_capture", 1, 3, 3, 4, 4, 0);
        check("pin_capture_valid", meas_valid, 1);
        run_move("black_double_blocked", 7, 6, 2, 4, 2, 1);
        run_move("queen_diag_blocked", 5, 0, 0, 7, 7, 0);
        run_move("king_step", 6, 3, 3, 4, 3, 0);

        // Abort during a path scan.
        @(negedge clk);
        piece_to_move = 4'd2; piece_x = 3'd0; piece_y = 3'd0;
        move_x = 3'd7; move_y = 3'd0; current_player = 1'b0;
        start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_done", int'(done), 0);
        quiet = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || valid !== 1'b0) quiet++;
        end
        check("abort_quiet", quiet, 0);
        $display("abort rook (0,0)->(7,0) dropped after edge 4 stray_done_cycles=%0d", quiet);
        run_move("after_abort", 3, 5, 2, 7, 3, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        piece_to_move = 4'd2; piece_x = 3'd0; piece_y = 3'd0;
        move_x = 3'd7; move_y = 3'd0; current_player = 1'b0;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("scan_addr_x", int'(validate_x), 2);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_done", int'(done), 0);
        check("midreset_valid", int'(valid), 0);
        check("midreset_vx", int'(validate_x), 0);
        check("midreset_vy", int'(validate_y), 0);
        $display("reset mid-scan done=%0d valid=%0d addr=(%0d,%0d)", done, valid, validate_x, validate_y);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Reset while a positive result is being held.
        @(negedge clk);
        piece_to_move = 4'd3; piece_x = 3'd5; piece_y = 3'd2;
        move_x = 3'd7; move_y = 3'd3; current_player = 1'b0;
        start = 1'b1;
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("held_done", int'(done), 1);
        check("held_valid", int'(valid), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("donereset_done", int'(done), 0);
        check("donereset_valid", int'(valid), 0);
        $display("reset while done waited=%0d done=%0d valid=%0d", waited, done, valid);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_move("after_reset", 6, 3, 3, 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
